// File: rtl/emern_video_out_pkg.sv
// Shared defaults (VGA 640x480@60), sync polarity levels and configuration checks
// for the emern display output stage. No logic, no latency.
package emern_video_out_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int DEF_WCOLOR    = 6;
   localparam int DEF_PIPE_LAT  = 2;
   localparam int DEF_CMD_GUARD = 2;
   localparam int PIPE_LAT_MAX  = 8;

   localparam bit SYNC_ACTIVE_LOW  = 1'b0;
   localparam bit SYNC_ACTIVE_HIGH = 1'b1;

   function automatic bit cfg_ok(input int pipe_lat, input int cmd_guard, input int v_blank);
      return (pipe_lat >= 0) && (pipe_lat <= PIPE_LAT_MAX) && (cmd_guard < v_blank);
   endfunction

endpackage

// File: rtl/emern_delay_line.sv
// Fixed-depth shift register with async reset and synchronous flush to an idle value.
// Latency DEPTH cycles; DEPTH=0 is a plain wire.
module emern_delay_line #(
   parameter int               WIDTH = 1,
   parameter int               DEPTH = 1,
   parameter logic [WIDTH-1:0] IDLE  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] data_o
);

   if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, rst, flush};
      assign data_o     = data_i;
   end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
         end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= IDLE;
         end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign data_o = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/emern_video_out.sv
// Raster counters, sync/DE generation delayed by the pixel-core latency, colour gating,
// vblank command window and frame pulse/counter. Video out lags col/row by PIPE_LAT+1 clk.
module emern_video_out
   import emern_video_out_pkg::*;
#(
   parameter int H_ACTIVE  = VGA_H_ACTIVE,
   parameter int H_FP      = VGA_H_FP,
   parameter int H_SYNC    = VGA_H_SYNC,
   parameter int H_BP      = VGA_H_BP,
   parameter int V_ACTIVE  = VGA_V_ACTIVE,
   parameter int V_FP      = VGA_V_FP,
   parameter int V_SYNC    = VGA_V_SYNC,
   parameter int V_BP      = VGA_V_BP,
   parameter bit HSYNC_POL = SYNC_ACTIVE_LOW,
   parameter bit VSYNC_POL = SYNC_ACTIVE_LOW,
   parameter int PIPE_LAT  = DEF_PIPE_LAT,
   parameter int WCOLOR    = DEF_WCOLOR,
   parameter int CMD_GUARD = DEF_CMD_GUARD
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic                                          enable,
   output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0] col,
   output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0] row,
   input  logic [WCOLOR-1:0]                             pixel_in,
   output logic [WCOLOR-1:0]                             pixel_out,
   output logic                                          de,
   output logic                                          h_sync,
   output logic                                          v_sync,
   output logic                                          cmd_en,
   output logic                                          frame_start,
   output logic [7:0]                                    frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int WX      = $clog2(H_TOTAL);
   localparam int WY      = $clog2(V_TOTAL);

   localparam logic [WX-1:0] H_LAST   = WX'(H_TOTAL - 1);
   localparam logic [WX-1:0] H_ACT    = WX'(H_ACTIVE);
   localparam logic [WX-1:0] HS_FIRST = WX'(H_ACTIVE + H_FP);
   localparam logic [WX-1:0] HS_LAST  = WX'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [WY-1:0] V_LAST   = WY'(V_TOTAL - 1);
   localparam logic [WY-1:0] V_ACT    = WY'(V_ACTIVE);
   localparam logic [WY-1:0] VS_FIRST = WY'(V_ACTIVE + V_FP);
   localparam logic [WY-1:0] VS_LAST  = WY'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic [WY-1:0] CMD_LAST = WY'(V_TOTAL - CMD_GUARD - 1);

   if (!cfg_ok(PIPE_LAT, CMD_GUARD, V_TOTAL - V_ACTIVE)) begin : g_cfg_err
      $error("emern_video_out: PIPE_LAT must be 0..8 and CMD_GUARD below the vblank length");
   end

   logic [WX-1:0]     col_q, col_d;
   logic [WY-1:0]     row_q, row_d;
   logic              run_q;
   logic              frame_wrap;
   logic              cmd_en_q, cmd_en_d;
   logic              frame_start_q, frame_start_d;
   logic [7:0]        frame_count_q, frame_count_d;
   logic              de_q, de_d, hs_q, hs_d, vs_q, vs_d;
   logic [WCOLOR-1:0] pix_q, pix_d;
   logic [2:0]        raw_flags, dly_flags;
   logic              flush;

   // run_q marks cycles whose col/row are live; the first cycle after enable rises
   // presents (0,0) without advancing so it carries the frame_start pulse.
   always_comb begin
      col_d         = col_q;
      row_d         = row_q;
      frame_wrap    = 1'b0;
      frame_count_d = frame_count_q;
      if (!enable || !run_q) begin
         col_d = '0;
         row_d = '0;
      end else if (col_q == H_LAST) begin
         col_d = '0;
         if (row_q == V_LAST) begin
            row_d      = '0;
            frame_wrap = 1'b1;
         end else begin
            row_d = row_q + 1'b1;
         end
      end else begin
         col_d = col_q + 1'b1;
      end
      if (frame_wrap) frame_count_d = frame_count_q + 8'd1;
      frame_start_d = enable && (col_d == '0) && (row_d == '0);
      cmd_en_d      = enable && (row_d >= V_ACT) && (row_d <= CMD_LAST);
   end

   assign raw_flags[2] = run_q && (col_q < H_ACT) && (row_q < V_ACT);
   assign raw_flags[1] = run_q && (col_q >= HS_FIRST) && (col_q <= HS_LAST);
   assign raw_flags[0] = run_q && (row_q >= VS_FIRST) && (row_q <= VS_LAST);
   assign flush        = ~enable;

   emern_delay_line #(
      .WIDTH (3),
      .DEPTH (PIPE_LAT),
      .IDLE  (3'b000)
   ) u_delay (
      .clk    (clk),
      .rst    (rst),
      .flush  (flush),
      .data_i (raw_flags),
      .data_o (dly_flags)
   );

   assign de_d  = enable && dly_flags[2];
   assign hs_d  = enable && dly_flags[1];
   assign vs_d  = enable && dly_flags[0];
   assign pix_d = de_d ? pixel_in : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_q         <= '0;
         row_q         <= '0;
         run_q         <= 1'b0;
         cmd_en_q      <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= 8'd0;
         de_q          <= 1'b0;
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         pix_q         <= '0;
      end else begin
         col_q         <= col_d;
         row_q         <= row_d;
         run_q         <= enable;
         cmd_en_q      <= cmd_en_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
         de_q          <= de_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         pix_q         <= pix_d;
      end
   end

   assign col         = col_q;
   assign row         = row_q;
   assign pixel_out   = pix_q;
   assign de          = de_q;
   assign h_sync      = hs_q ? HSYNC_POL : ~HSYNC_POL;
   assign v_sync      = vs_q ? VSYNC_POL : ~VSYNC_POL;
   assign cmd_en      = cmd_en_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_emern_video_out.sv
// Bench for emern_video_out: a PIPE_LAT=2 instance and the small PIPE_LAT=0 active-high
// instance, checked every cycle against a raster model plus directed frame statistics.
module tb_emern_video_out;

   localparam int HA  [2] = '{8, 4};
   localparam int HF  [2] = '{2, 1};
   localparam int HSW [2] = '{3, 2};
   localparam int HB  [2] = '{3, 1};
   localparam int VA  [2] = '{6, 3};
   localparam int VF  [2] = '{1, 1};
   localparam int VSW [2] = '{2, 1};
   localparam int VB  [2] = '{2, 1};
   localparam int POL [2] = '{0, 1};
   localparam int LAT [2] = '{2, 0};
   localparam int GRD [2] = '{2, 2};
   localparam int RUN     = 1 + 176 * 257;

   typedef struct packed {
      logic       de;
      logic       hs;
      logic       vs;
      logic [5:0] c;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   bit         force_3f;

   logic [3:0] col_a, row_a;
   logic [5:0] pin_a, pout_a;
   logic       de_a, hs_a, vs_a, cmd_a, fs_a;
   logic [7:0] fc_a;
   logic [2:0] col_b, row_b;
   logic [5:0] pin_b, pout_b;
   logic       de_b, hs_b, vs_b, cmd_b, fs_b;
   logic [7:0] fc_b;
   logic [3:0] pc1, pc2;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb_a[$];
   exp_t sb_b[$];
   int   m_c [2];
   int   m_r [2];
   int   m_fc[2];
   bit   m_run[2];
   bit   x_de[2], x_hs[2], x_vs[2], x_cmd[2], x_fs[2];
   logic [5:0] x_pix[2];

   always #5 clk = ~clk;

   // Pixel-core models: A returns its colour two clocks after the coordinate, B at once.
   always_ff @(posedge clk) begin
      pc1 <= col_a;
      pc2 <= pc1;
   end
   assign pin_a = force_3f ? 6'h3F : {2'b00, pc2};
   assign pin_b = {3'b101, col_b};

   emern_video_out #(
      .H_ACTIVE(HA[0]), .H_FP(HF[0]), .H_SYNC(HSW[0]), .H_BP(HB[0]),
      .V_ACTIVE(VA[0]), .V_FP(VF[0]), .V_SYNC(VSW[0]), .V_BP(VB[0]),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_LAT(LAT[0]), .WCOLOR(6), .CMD_GUARD(GRD[0])
   ) u_dut_a (
      .clk(clk), .rst(rst), .enable(enable), .col(col_a), .row(row_a),
      .pixel_in(pin_a), .pixel_out(pout_a), .de(de_a), .h_sync(hs_a), .v_sync(vs_a),
      .cmd_en(cmd_a), .frame_start(fs_a), .frame_count(fc_a)
   );

   emern_video_out #(
      .H_ACTIVE(HA[1]), .H_FP(HF[1]), .H_SYNC(HSW[1]), .H_BP(HB[1]),
      .V_ACTIVE(VA[1]), .V_FP(VF[1]), .V_SYNC(VSW[1]), .V_BP(VB[1]),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_LAT(LAT[1]), .WCOLOR(6), .CMD_GUARD(GRD[1])
   ) u_dut_b (
      .clk(clk), .rst(rst), .enable(enable), .col(col_b), .row(row_b),
      .pixel_in(pin_b), .pixel_out(pout_b), .de(de_b), .h_sync(hs_b), .v_sync(vs_b),
      .cmd_en(cmd_b), .frame_start(fs_b), .frame_count(fc_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t raw_f(input int id, input int c, input int r);
      exp_t e;
      e.de = (c < HA[id]) && (r < VA[id]);
      e.hs = (c >= HA[id] + HF[id]) && (c < HA[id] + HF[id] + HSW[id]);
      e.vs = (r >= VA[id] + VF[id]) && (r < VA[id] + VF[id] + VSW[id]);
      e.c  = 6'(c);
      return e;
   endfunction

   task automatic reset_models();
      exp_t idle = '0;
      sb_a.delete();
      sb_b.delete();
      repeat (LAT[0]) sb_a.push_back(idle);
      repeat (LAT[1]) sb_b.push_back(idle);
      for (int id = 0; id < 2; id++) begin
         m_c[id] = 0; m_r[id] = 0; m_fc[id] = 0; m_run[id] = 1'b0;
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_a_col"}, 32'(col_a), 0);
      chk({tag, "_a_row"}, 32'(row_a), 0);
      chk({tag, "_a_pix"}, 32'(pout_a), 0);
      chk({tag, "_a_de"}, 32'(de_a), 0);
      chk({tag, "_a_hsync"}, 32'(hs_a), 1);
      chk({tag, "_a_vsync"}, 32'(vs_a), 1);
      chk({tag, "_a_cmd"}, 32'(cmd_a), 0);
      chk({tag, "_a_fstart"}, 32'(fs_a), 0);
      chk({tag, "_a_fcount"}, 32'(fc_a), 0);
      chk({tag, "_b_hsync"}, 32'(hs_b), 0);
      chk({tag, "_b_vsync"}, 32'(vs_b), 0);
      chk({tag, "_b_de"}, 32'(de_b), 0);
   endtask

   // One clock: expected values for the edge are pushed/popped before it, compared 1 ns after.
   task automatic tick();
      exp_t e;
      exp_t idle = '0;
      int   ht, vt;
      for (int id = 0; id < 2; id++) begin
         ht = HA[id] + HF[id] + HSW[id] + HB[id];
         vt = VA[id] + VF[id] + VSW[id] + VB[id];
         if (!enable) begin
            if (id == 0) begin sb_a.delete(); repeat (LAT[0]) sb_a.push_back(idle); end
            else         begin sb_b.delete(); repeat (LAT[1]) sb_b.push_back(idle); end
            e = idle;
         end else begin
            e = m_run[id] ? raw_f(id, m_c[id], m_r[id]) : idle;
            if (id == 0) begin sb_a.push_back(e); e = sb_a.pop_front(); end
            else         begin sb_b.push_back(e); e = sb_b.pop_front(); end
         end
         x_de[id]  = e.de;
         x_hs[id]  = e.hs ? POL[id][0] : !POL[id][0];
         x_vs[id]  = e.vs ? POL[id][0] : !POL[id][0];
         x_pix[id] = !e.de ? 6'd0 : (id == 0 ? (force_3f ? 6'h3F : e.c) : {3'b101, e.c[2:0]});
         if (enable && m_run[id] && m_c[id] == ht - 1 && m_r[id] == vt - 1)
            m_fc[id] = (m_fc[id] + 1) % 256;
         if (!enable || !m_run[id]) begin
            m_c[id] = 0; m_r[id] = 0;
         end else if (m_c[id] == ht - 1) begin
            m_c[id] = 0;
            m_r[id] = (m_r[id] == vt - 1) ? 0 : m_r[id] + 1;
         end else begin
            m_c[id]++;
         end
         x_fs[id]  = enable && m_c[id] == 0 && m_r[id] == 0;
         x_cmd[id] = enable && m_r[id] >= VA[id] && m_r[id] < vt - GRD[id];
         m_run[id] = enable;
      end
      @(posedge clk);
      #1;
      chk("a_col", 32'(col_a), 32'(m_c[0]));
      chk("a_row", 32'(row_a), 32'(m_r[0]));
      chk("a_de", 32'(de_a), 32'(x_de[0]));
      chk("a_hsync", 32'(hs_a), 32'(x_hs[0]));
      chk("a_vsync", 32'(vs_a), 32'(x_vs[0]));
      chk("a_pix", 32'(pout_a), 32'(x_pix[0]));
      chk("a_cmd", 32'(cmd_a), 32'(x_cmd[0]));
      chk("a_fstart", 32'(fs_a), 32'(x_fs[0]));
      chk("a_fcount", 32'(fc_a), 32'(m_fc[0]));
      chk("b_col", 32'(col_b), 32'(m_c[1]));
      chk("b_row", 32'(row_b), 32'(m_r[1]));
      chk("b_de", 32'(de_b), 32'(x_de[1]));
      chk("b_hsync", 32'(hs_b), 32'(x_hs[1]));
      chk("b_vsync", 32'(vs_b), 32'(x_vs[1]));
      chk("b_pix", 32'(pout_b), 32'(x_pix[1]));
      chk("b_cmd", 32'(cmd_b), 32'(x_cmd[1]));
      chk("b_fstart", 32'(fs_b), 32'(x_fs[1]));
      chk("b_fcount", 32'(fc_b), 32'(m_fc[1]));
   endtask

   int nfs_a, last_fs, saved_fc, found;
   int a_de_n, a_hs_n, a_vs_n, b_de_n, b_hs_n, b_vs_n, b_fs_n;
   bit prev_cmd;

   initial begin
      rst = 1'b1; enable = 1'b0; force_3f = 1'b0;
      nfs_a = 0; last_fs = 0; prev_cmd = 1'b0; found = 0;
      a_de_n = 0; a_hs_n = 0; a_vs_n = 0; b_de_n = 0; b_hs_n = 0; b_vs_n = 0; b_fs_n = 0;
      reset_models();
      repeat (2) @(posedge clk);
      #1;
      check_reset("reset");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) tick();

      enable = 1'b1;
      for (int i = 1; i <= RUN; i++) begin
         tick();
         if (fs_a) begin
            nfs_a++;
            if (last_fs > 0) chk("a_frame_period", 32'(i - last_fs), 176);
            last_fs = i;
         end
         if (i == 177) chk("a_fcount_first_wrap", 32'(fc_a), 1);
         if (cmd_a && !prev_cmd) chk("a_cmd_rise_row", 32'(row_a), 6);
         if (!cmd_a && prev_cmd) chk("a_cmd_fall_row", 32'(row_a), 9);
         prev_cmd = cmd_a;
         if (i >= 201 && i <= 376) begin
            a_de_n += int'(de_a); a_hs_n += int'(!hs_a); a_vs_n += int'(!vs_a);
         end
         if (i >= 201 && i <= 248) begin
            b_de_n += int'(de_b); b_hs_n += int'(hs_b); b_vs_n += int'(vs_b); b_fs_n += int'(fs_b);
         end
         if (i == 399) force_3f = 1'b1;
         if (i == 800) force_3f = 1'b0;
      end
      chk("a_de_per_frame", 32'(a_de_n), 48);
      chk("a_hsync_low_per_frame", 32'(a_hs_n), 33);
      chk("a_vsync_low_per_frame", 32'(a_vs_n), 32);
      chk("b_de_per_frame", 32'(b_de_n), 12);
      chk("b_hsync_high_per_frame", 32'(b_hs_n), 12);
      chk("b_vsync_high_per_frame", 32'(b_vs_n), 8);
      chk("b_fstart_per_48", 32'(b_fs_n), 1);
      chk("a_fcount_257_wraps", 32'(fc_a), 1);
      chk("a_fstart_total", 32'(nfs_a), 258);

      for (int k = 0; k < 300 && found == 0; k++) begin
         tick();
         if (m_c[0] == 5 && m_r[0] == 3) found = 1;
      end
      chk("a_seek_col5_row3", 32'(found), 1);
      saved_fc = int'(fc_a);
      enable = 1'b0;
      tick();
      chk("dis_col", 32'(col_a), 0);
      chk("dis_row", 32'(row_a), 0);
      chk("dis_de", 32'(de_a), 0);
      chk("dis_hsync", 32'(hs_a), 1);
      chk("dis_vsync", 32'(vs_a), 1);
      chk("dis_fcount_hold", 32'(fc_a), 32'(saved_fc));
      repeat (3) tick();
      enable = 1'b1;
      tick();
      chk("reen_fstart", 32'(fs_a), 1);
      chk("reen_col", 32'(col_a), 0);
      repeat (50) tick();

      #2;
      rst = 1'b1;
      #1;
      check_reset("async_rst");
      @(negedge clk);
      rst = 1'b0;
      reset_models();
      tick();
      chk("post_rst_fstart", 32'(fs_a), 1);
      repeat (200) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
